serial_in_parallel_out: RTL and testbench

- Receive side of the 4-bit parallel-in/serial-out link: deserializes the bit stream from the shift register back into a parallel word.
- Start-of-word framing, a bit counter, resync on an early start, and a valid/ready output register with overrun detection.
- Sits between the serial link and the ALU operand registers.

---
 rtl/serial_in_parallel_out_if.sv | 28 ++
 rtl/serial_in_parallel_out.sv | 126 ++++++++++++
 tb/tb_serial_in_parallel_out.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/serial_in_parallel_out_if.sv
// Serial receive link bundle: bit stream in, word handshake and status out.
interface serial_in_parallel_out_if #(
   parameter int unsigned WIDTH = 4
) ();

   logic             shift_en;
   logic             din;
   logic             start;
   logic             q_ready;
   logic [WIDTH-1:0] q;
   logic             q_valid;
   logic             busy;
   logic             sync_err;
   logic             overrun;

   // Link/consumer side: drives the bit stream and q_ready.
   modport master (
      output shift_en, din, start, q_ready,
      input  q, q_valid, busy, sync_err, overrun
   );

   // Deserializer side.
   modport slave (
      input  shift_en, din, start, q_ready,
      output q, q_valid, busy, sync_err, overrun
   );

endinterface

// File: rtl/serial_in_parallel_out.sv
// Deserializer: start-framed bit stream in, parallel word out through a
// single-entry valid/ready register. An early start resyncs and flags sync_err;
// a word that completes while the register is full is dropped and flags overrun.
module serial_in_parallel_out #(
   parameter int unsigned WIDTH     = 4,
   parameter bit          MSB_FIRST = 1'b1
) (
   input logic                     clk,
   input logic                     rst,
   serial_in_parallel_out_if.slave bus
);

   localparam int unsigned CntW = $clog2(WIDTH + 1);

   typedef enum logic {StIdle, StRecv} state_t;

   state_t            r_state, w_state_d;
   logic [WIDTH-1:0]  r_sr, w_sr_d;
   logic [CntW-1:0]   r_cnt, w_cnt_d;
   logic [WIDTH-1:0]  r_q, w_q_d;
   logic              r_q_valid, w_q_valid_d;
   logic              r_overrun, w_overrun_d;
   logic              r_sync_err;

   logic [WIDTH-1:0]  w_shift_base;
   logic [WIDTH-1:0]  w_shifted;
   logic              w_complete;
   logic              w_resync;

   // A start bit always shifts into a cleared register.
   assign w_shift_base = bus.start ? '0 : r_sr;

   if (MSB_FIRST) begin : g_msb_first
      assign w_shifted = {w_shift_base[WIDTH-2:0], bus.din};
   end else begin : g_lsb_first
      assign w_shifted = {bus.din, w_shift_base[WIDTH-1:1]};
   end

   // Framing FSM next state: start detection, bit counting, resync, completion.
   always_comb begin
      w_state_d  = r_state;
      w_sr_d     = r_sr;
      w_cnt_d    = r_cnt;
      w_complete = 1'b0;
      w_resync   = 1'b0;
      unique case (r_state)
         StIdle: begin
            if (bus.shift_en && bus.start) begin
               w_state_d = StRecv;
               w_sr_d    = w_shifted;
               w_cnt_d   = CntW'(1);
            end
         end
         StRecv: begin
            if (bus.shift_en) begin
               w_sr_d = w_shifted;
               if (bus.start) begin
                  w_resync = 1'b1;
                  w_cnt_d  = CntW'(1);
               end else if (r_cnt == CntW'(WIDTH - 1)) begin
                  w_complete = 1'b1;
                  w_cnt_d    = '0;
                  w_state_d  = StIdle;
               end else begin
                  w_cnt_d = r_cnt + CntW'(1);
               end
            end
         end
         default: begin
            w_state_d = StIdle;
         end
      endcase
   end

   // Output register: accept completed word if empty or draining this edge.
   always_comb begin
      w_q_d       = r_q;
      w_q_valid_d = r_q_valid;
      w_overrun_d = r_overrun;
      if (w_complete) begin
         if (!r_q_valid || bus.q_ready) begin
            w_q_d       = w_shifted;
            w_q_valid_d = 1'b1;
         end else begin
            w_overrun_d = 1'b1;
         end
      end else if (r_q_valid && bus.q_ready) begin
         w_q_valid_d = 1'b0;
      end
   end

   // Framing state registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= StIdle;
         r_sr    <= '0;
         r_cnt   <= '0;
      end else begin
         r_state <= w_state_d;
         r_sr    <= w_sr_d;
         r_cnt   <= w_cnt_d;
      end
   end

   // Output word, handshake and status registers.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_q        <= '0;
         r_q_valid  <= 1'b0;
         r_overrun  <= 1'b0;
         r_sync_err <= 1'b0;
      end else begin
         r_q        <= w_q_d;
         r_q_valid  <= w_q_valid_d;
         r_overrun  <= w_overrun_d;
         r_sync_err <= w_resync;
      end
   end

   assign bus.q        = r_q;
   assign bus.q_valid  = r_q_valid;
   assign bus.busy     = (r_state == StRecv);
   assign bus.sync_err = r_sync_err;
   assign bus.overrun  = r_overrun;

endmodule

// File: tb/tb_serial_in_parallel_out.sv
// Bench for serial_in_parallel_out: MSB-first and LSB-first instances share
// stimulus and are compared every cycle against a bit-queue reference model.
module tb_serial_in_parallel_out;

   localparam int unsigned W = 4;

   logic clk;
   logic rst;

   serial_in_parallel_out_if #(.WIDTH(W)) if_msb ();
   serial_in_parallel_out_if #(.WIDTH(W)) if_lsb ();

   serial_in_parallel_out #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk (clk),
      .rst (rst),
      .bus (if_msb)
   );

   serial_in_parallel_out #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk (clk),
      .rst (rst),
      .bus (if_lsb)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model: received bits of the current word, oldest first.
   bit         m_bits[$];
   logic [3:0] m_q_msb, m_q_lsb;
   bit         m_qv, m_ovr, m_serr;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic void model_reset();
      m_bits.delete();
      m_q_msb = '0;
      m_q_lsb = '0;
      m_qv    = 1'b0;
      m_ovr   = 1'b0;
      m_serr  = 1'b0;
   endfunction

   function automatic void model_step(input bit se, input bit d, input bit st, input bit rdy);
      bit complete;
      int wm;
      int wl;
      complete = 1'b0;
      wm = 0;
      wl = 0;
      m_serr = 1'b0;
      if (se) begin
         if (st) begin
            if (m_bits.size() > 0) m_serr = 1'b1;
            m_bits.delete();
            m_bits.push_back(d);
         end else if (m_bits.size() > 0) begin
            m_bits.push_back(d);
         end
         if (m_bits.size() == W) begin
            for (int i = 0; i < W; i++) begin
               if (m_bits[i]) begin
                  wm = wm + (1 << (W - 1 - i));
                  wl = wl + (1 << i);
               end
            end
            complete = 1'b1;
            m_bits.delete();
         end
      end
      if (complete) begin
         if (!m_qv || rdy) begin
            m_q_msb = 4'(wm);
            m_q_lsb = 4'(wl);
            m_qv    = 1'b1;
         end else begin
            m_ovr = 1'b1;
         end
      end else if (m_qv && rdy) begin
         m_qv = 1'b0;
      end
   endfunction

   task automatic compare_model();
      check("msb_q",        {28'd0, if_msb.q},  {28'd0, m_q_msb});
      check("lsb_q",        {28'd0, if_lsb.q},  {28'd0, m_q_lsb});
      check("msb_q_valid",  {31'd0, if_msb.q_valid},  {31'd0, m_qv});
      check("lsb_q_valid",  {31'd0, if_lsb.q_valid},  {31'd0, m_qv});
      check("msb_busy",     {31'd0, if_msb.busy},     {31'd0, m_bits.size() != 0});
      check("lsb_busy",     {31'd0, if_lsb.busy},     {31'd0, m_bits.size() != 0});
      check("msb_sync_err", {31'd0, if_msb.sync_err}, {31'd0, m_serr});
      check("lsb_sync_err", {31'd0, if_lsb.sync_err}, {31'd0, m_serr});
      check("msb_overrun",  {31'd0, if_msb.overrun},  {31'd0, m_ovr});
      check("lsb_overrun",  {31'd0, if_lsb.overrun},  {31'd0, m_ovr});
   endtask

   // Apply one cycle of stimulus to both instances, then check after the edge.
   task automatic drive(input bit se, input bit d, input bit st, input bit rdy);
      if_msb.shift_en = se;
      if_msb.din      = d;
      if_msb.start    = st;
      if_msb.q_ready  = rdy;
      if_lsb.shift_en = se;
      if_lsb.din      = d;
      if_lsb.start    = st;
      if_lsb.q_ready  = rdy;
      @(posedge clk);
      model_step(se, d, st, rdy);
      #1;
      compare_model();
   endtask

   typedef struct {
      bit         se;
      bit         din;
      bit         st;
      bit         rdy;
      logic [3:0] q;
      bit         qv;
      bit         busy;
      bit         serr;
      bit         ovr;
   } vec_t;

   vec_t vecs[5];

   initial begin
      // Basic MSB-first word 1,0,0,1 with q_ready=1; expectations for u_msb.
      vecs[0] = '{se: 1, din: 1, st: 1, rdy: 1, q: 4'b0000, qv: 0, busy: 1, serr: 0, ovr: 0};
      vecs[1] = '{se: 1, din: 0, st: 0, rdy: 1, q: 4'b0000, qv: 0, busy: 1, serr: 0, ovr: 0};
      vecs[2] = '{se: 1, din: 0, st: 0, rdy: 1, q: 4'b0000, qv: 0, busy: 1, serr: 0, ovr: 0};
      vecs[3] = '{se: 1, din: 1, st: 0, rdy: 1, q: 4'b1001, qv: 1, busy: 0, serr: 0, ovr: 0};
      vecs[4] = '{se: 0, din: 0, st: 0, rdy: 1, q: 4'b1001, qv: 0, busy: 0, serr: 0, ovr: 0};

      rst = 1'b1;
      if_msb.shift_en = 0; if_msb.din = 0; if_msb.start = 0; if_msb.q_ready = 0;
      if_lsb.shift_en = 0; if_lsb.din = 0; if_lsb.start = 0; if_lsb.q_ready = 0;
      model_reset();
      #12 rst = 1'b0;
      @(posedge clk);
      #1;
      check("reset_q",       {28'd0, if_msb.q}, 32'd0);
      check("reset_q_valid", {31'd0, if_msb.q_valid}, 32'd0);
      check("reset_busy",    {31'd0, if_msb.busy}, 32'd0);
      check("reset_overrun", {31'd0, if_msb.overrun}, 32'd0);
      compare_model();

      // Table-driven basic word.
      for (int i = 0; i < 5; i++) begin
         drive(vecs[i].se, vecs[i].din, vecs[i].st, vecs[i].rdy);
         check("vec_q",        {28'd0, if_msb.q},        {28'd0, vecs[i].q});
         check("vec_q_valid",  {31'd0, if_msb.q_valid},  {31'd0, vecs[i].qv});
         check("vec_busy",     {31'd0, if_msb.busy},     {31'd0, vecs[i].busy});
         check("vec_sync_err", {31'd0, if_msb.sync_err}, {31'd0, vecs[i].serr});
         check("vec_overrun",  {31'd0, if_msb.overrun},  {31'd0, vecs[i].ovr});
      end

      // LSB-first back-to-back words 1,0,0,1 then 1,1,0,0.
      drive(1, 1, 1, 1); drive(1, 0, 0, 1); drive(1, 0, 0, 1); drive(1, 1, 0, 1);
      check("lsb_word1", {28'd0, if_lsb.q}, 32'b1001);
      drive(1, 1, 1, 1); drive(1, 1, 0, 1); drive(1, 0, 0, 1); drive(1, 0, 0, 1);
      check("lsb_word2",     {28'd0, if_lsb.q}, 32'b0011);
      check("lsb_word2_qv",  {31'd0, if_lsb.q_valid}, 32'd1);
      check("lsb_word2_ovr", {31'd0, if_lsb.overrun}, 32'd0);

      // Gap of 3 idle cycles between bits 2 and 3.
      drive(1, 1, 1, 1); drive(1, 1, 0, 1);
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 0, 1);
         check("gap_busy", {31'd0, if_msb.busy}, 32'd1);
      end
      drive(1, 0, 0, 1);
      check("gap_not_done", {31'd0, if_msb.busy}, 32'd1);
      drive(1, 1, 0, 1);
      check("gap_word", {28'd0, if_msb.q}, 32'b1101);
      check("gap_qv",   {31'd0, if_msb.q_valid}, 32'd1);

      // Resync: 1,1 then a fresh start with 0,1,1,0.
      drive(1, 1, 1, 1); drive(1, 1, 0, 1);
      drive(1, 0, 1, 1);
      check("resync_pulse", {31'd0, if_msb.sync_err}, 32'd1);
      drive(1, 1, 0, 1);
      check("resync_one_cycle", {31'd0, if_msb.sync_err}, 32'd0);
      drive(1, 1, 0, 1); drive(1, 0, 0, 1);
      check("resync_word_msb", {28'd0, if_msb.q}, 32'b0110);
      check("resync_word_lsb", {28'd0, if_lsb.q}, 32'b0110);

      // Overrun: q_ready low across two words, then drain.
      drive(0, 0, 0, 1);
      drive(1, 1, 1, 0); drive(1, 0, 0, 0); drive(1, 1, 0, 0); drive(1, 0, 0, 0);
      drive(1, 0, 1, 0); drive(1, 1, 0, 0); drive(1, 0, 0, 0); drive(1, 1, 0, 0);
      check("ovr_q_msb", {28'd0, if_msb.q}, 32'b1010);
      check("ovr_q_lsb", {28'd0, if_lsb.q}, 32'b0101);
      check("ovr_qv",    {31'd0, if_msb.q_valid}, 32'd1);
      check("ovr_flag",  {31'd0, if_msb.overrun}, 32'd1);
      drive(0, 0, 0, 1);
      check("ovr_drained", {31'd0, if_msb.q_valid}, 32'd0);
      check("ovr_sticky",  {31'd0, if_msb.overrun}, 32'd1);

      // Asynchronous reset mid-word, off the clock edge.
      drive(1, 1, 1, 0); drive(1, 0, 0, 0);
      #2 rst = 1'b1;
      #1;
      check("arst_busy",    {31'd0, if_msb.busy}, 32'd0);
      check("arst_q_valid", {31'd0, if_msb.q_valid}, 32'd0);
      check("arst_q",       {28'd0, if_msb.q}, 32'd0);
      check("arst_overrun", {31'd0, if_msb.overrun}, 32'd0);
      #2 rst = 1'b0;
      model_reset();
      drive(1, 0, 1, 1); drive(1, 1, 0, 1); drive(1, 1, 0, 1); drive(1, 1, 0, 1);
      check("post_rst_msb", {28'd0, if_msb.q}, 32'b0111);
      check("post_rst_lsb", {28'd0, if_lsb.q}, 32'b1110);

      // Randomized traffic against the reference model.
      for (int i = 0; i < 400; i++) begin
         drive(bit'($urandom_range(0, 3) != 0), bit'($urandom_range(0, 1)),
               bit'($urandom_range(0, 5) == 0), bit'($urandom_range(0, 2) != 0));
      end

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
